// File: rtl/conv_window_feeder.sv
// conv_window_feeder: raster pixel stream to 5-row vertical columns for the conv sliding window
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   start      level; rising edge arms a frame, low aborts to IDLE
//   state      frame size select (0 = 28x28, 1 = 12x12), latched on start rising edge
//   din        pixel in raster order
//   din_valid  pixel strobe, always accepted in RUN
//   taps       column {row r-4 .. row r}, current row in the low byte
//   taps_valid taps holds a full K-row column
//   tap_col    column index of taps
//   tap_row    row index of taps
//   frame_done one-cycle pulse with the last column of the frame
module conv_window_feeder #(
    parameter int K    = 5,
    parameter int DW   = 8,
    parameter int NMAX = 28
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic            state,
    input  logic [DW-1:0]   din,
    input  logic            din_valid,
    output logic [K*DW-1:0] taps,
    output logic            taps_valid,
    output logic [4:0]      tap_col,
    output logic [4:0]      tap_row,
    output logic            frame_done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;
    fsm_t fsm, fsm_nx;
    logic start_d, size_q, acc, eol, eof;
    logic [4:0] row, col, last;
    logic [DW-1:0] lm [K-1][NMAX];
    logic [K*DW-1:0] column;

    assign last = size_q ? 5'd11 : 5'd27;
    // start low overrides acceptance: the abort cycle itself discards the pixel
    assign acc  = fsm == RUN && start && din_valid;
    assign eol  = col == last;
    assign eof  = eol && row == last;

    always_comb begin
        fsm_nx = fsm;
        if (!start)
            fsm_nx = IDLE;
        else if (fsm == IDLE && !start_d)
            fsm_nx = RUN;
        else if (acc && eof)
            fsm_nx = DONE;
    end

    // rows above the frame top are forced to zero so stale line memory never leaks out
    always_comb begin
        column = '0;
        column[DW-1:0] = din;
        for (int k = 0; k < K-1; k++)
            column[(k+1)*DW +: DW] = (int'(row) > k) ? lm[k][col] : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fsm        <= IDLE;
            start_d    <= 1'b0;
            size_q     <= 1'b0;
            row        <= '0;
            col        <= '0;
            taps       <= '0;
            taps_valid <= 1'b0;
            tap_col    <= '0;
            tap_row    <= '0;
            frame_done <= 1'b0;
        end else begin
            fsm     <= fsm_nx;
            start_d <= start;
            if (fsm == IDLE && start && !start_d) begin
                size_q <= state;
                row    <= '0;
                col    <= '0;
            end else if (acc) begin
                col <= eol ? 5'd0 : col + 5'd1;
                if (eol)
                    row <= row + 5'd1;
            end
            if (!start) begin
                taps       <= '0;
                taps_valid <= 1'b0;
                tap_col    <= '0;
                tap_row    <= '0;
                frame_done <= 1'b0;
            end else if (acc) begin
                taps       <= column;
                taps_valid <= row >= 5'(K-1);
                tap_col    <= col;
                tap_row    <= row;
                frame_done <= eof;
            end else begin
                taps_valid <= 1'b0;
                frame_done <= 1'b0;
            end
        end
    end

    // line memories shift down one row per write at the current column
    always_ff @(posedge clk) begin
        if (acc) begin
            lm[0][col] <= din;
            for (int k = 1; k < K-1; k++)
                lm[k][col] <= lm[k-1][col];
        end
    end
endmodule

// File: tb/tb_conv_window_feeder.sv
// tb_conv_window_feeder: scoreboard bench for conv_window_feeder against an image-level reference model
module tb_conv_window_feeder;
    logic        clk = 1'b0;
    logic        rstn, start, state, din_valid;
    logic [7:0]  din;
    logic [39:0] taps;
    logic        taps_valid, frame_done;
    logic [4:0]  tap_col, tap_row;

    typedef struct {
        logic [39:0] t;
        logic [4:0]  r;
        logic [4:0]  c;
        logic        d;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int checks = 0;
    int fails  = 0;
    int vcount = 0;
    int dcount = 0;

    conv_window_feeder dut (
        .clk(clk), .rstn(rstn), .start(start), .state(state),
        .din(din), .din_valid(din_valid),
        .taps(taps), .taps_valid(taps_valid), .tap_col(tap_col),
        .tap_row(tap_row), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pix(input int pat, input int r, input int c);
        return pat == 0 ? 8'((r + c) % 256) : 8'(r * 12 + c);
    endfunction

    // column (r,c) of the image: rows r-4..r stacked, rows outside the frame read as 0
    function automatic logic [39:0] exp_taps(input int pat, input int r, input int c);
        logic [39:0] t = '0;
        for (int k = 0; k < 5; k++)
            if (r - k >= 0)
                t[8*k +: 8] = pix(pat, r - k, c);
        return t;
    endfunction

    always @(negedge clk) begin
        if (rstn && frame_done)
            chk("done_with_valid", taps_valid, 1);
        if (rstn && taps_valid) begin
            vcount++;
            if (frame_done)
                dcount++;
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL sb_unexpected actual row=%0d col=%0d required=none", tap_row, tap_col);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_taps", taps, mon_e.t);
                chk("sb_rowcol", {tap_row, tap_col}, {mon_e.r, mon_e.c});
                chk("sb_done", frame_done, mon_e.d);
            end
        end
    end

    task automatic chk_zero(input string nm);
        chk(nm, {taps, taps_valid, tap_row, tap_col, frame_done}, 0);
    endtask

    // mode: 0 full frame, 1 drop start at (ar,ac), 2 pulse rstn at (ar,ac)
    task automatic run_frame(input bit sz, input int pat, input bit duty, input bit tog,
                             input int mode, input int ar, input int ac);
        int ni = sz ? 12 : 28;
        logic [39:0] lt = '0;
        start = 1'b0;
        din_valid = 1'b0;
        tick();
        state = sz;
        start = 1'b1;
        tick();
        vcount = 0;
        dcount = 0;
        for (int r = 0; r < ni; r++) begin
            for (int c = 0; c < ni; c++) begin
                if (duty) begin
                    repeat ($urandom_range(0, 2)) begin
                        din_valid = 1'b0;
                        din = 8'($urandom);
                        tick();
                        if (r != 0 || c != 0) begin
                            chk("gap_hold_taps", taps, lt);
                            chk("gap_valid", taps_valid, 0);
                        end
                    end
                end
                if (tog)
                    state = 1'($urandom);
                din = pix(pat, r, c);
                din_valid = 1'b1;
                if (mode != 0 && r == ar && c == ac) begin
                    if (mode == 1) begin
                        start = 1'b0;
                        tick();
                        din_valid = 1'b0;
                        chk_zero("abort_outputs");
                    end else begin
                        din_valid = 1'b0;
                        @(negedge clk);
                        #1;
                        rstn = 1'b0;
                        #1;
                        chk_zero("async_reset_outputs");
                        rstn = 1'b1;
                        start = 1'b0;
                        tick();
                        chk_zero("post_reset_outputs");
                    end
                    return;
                end
                if (r >= 4)
                    sb.push_back('{exp_taps(pat, r, c), 5'(r), 5'(c), r == ni-1 && c == ni-1});
                tick();
                lt = exp_taps(pat, r, c);
                chk("col_taps", taps, lt);
                chk("col_valid", taps_valid, r >= 4);
                chk("col_rowcol", {tap_row, tap_col}, {5'(r), 5'(c)});
                chk("col_done", frame_done, r == ni-1 && c == ni-1);
                if (pat == 0 && r == 4 && c == 0)   chk("first_taps28", taps, 40'h0001020304);
                if (pat == 0 && r == 27 && c == 27) chk("last_taps28", taps, 40'h3233343536);
                if (pat == 0 && r == 1 && c == 3)   chk("mask_1_3", taps, 40'h0000000304);
                if (pat == 0 && r == 0 && c == 0)   chk("mask_0_0", taps, 0);
                if (pat == 1 && r == 4 && c == 0)   chk("first_taps12", taps, 40'h000C182430);
            end
        end
        din_valid = 1'b0;
        repeat (3) tick();
        chk("valid_count", vcount, (ni - 4) * ni);
        chk("done_count", dcount, 1);
        chk("sb_drained", sb.size(), 0);
    endtask

    task automatic done_hold();
        repeat (8) begin
            din_valid = 1'b1;
            din = 8'($urandom);
            tick();
            chk("done_hold_valid", taps_valid, 0);
            chk("done_hold_done", frame_done, 0);
        end
        din_valid = 1'b0;
        start = 1'b0;
        tick();
        chk_zero("done_exit_outputs");
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        start = 1'b0;
        state = 1'b0;
        din = '0;
        din_valid = 1'b0;
        repeat (3) tick();
        chk_zero("reset_outputs");
        rstn = 1'b1;
        tick();
        din_valid = 1'b1;
        tick();
        chk("idle_ignores_valid", taps_valid, 0);
        run_frame(1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
        done_hold();
        run_frame(1'b1, 1, 1'b0, 1'b1, 0, 0, 0);
        run_frame(1'b0, 0, 1'b1, 1'b0, 0, 0, 0);
        run_frame(1'b0, 0, 1'b0, 1'b0, 1, 10, 5);
        run_frame(1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
        run_frame(1'b0, 0, 1'b0, 1'b0, 2, 10, 5);
        run_frame(1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
